// File: rtl/halt_drain_ctrl_pkg.sv
// Shared definitions for the halt/drain controller: state encodings and default sizing.
package halt_drain_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } halt_state_t;

  localparam int DEF_CNT_W     = 8;
  localparam int DEF_DRAIN_MAX = 64;
  localparam int TIMER_W       = 16;

endpackage

// File: rtl/halt_drain_ctrl_if.sv
// Issue/retire/halt bundle between the pipeline (master) and the halt/drain controller (slave).
interface halt_drain_ctrl_if
  import halt_drain_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             issue_v;
  logic             issue_halt;
  logic             wb_v;
  logic             W_v;
  logic             stop_fetch;
  logic             isHalt;
  logic [CNT_W-1:0] inflight;
  logic             proto_err;
  logic             drain_err;

  modport master (
    output issue_v, issue_halt, wb_v,
    input  W_v, stop_fetch, isHalt, inflight, proto_err, drain_err
  );

  modport slave (
    input  issue_v, issue_halt, wb_v,
    output W_v, stop_fetch, isHalt, inflight, proto_err, drain_err
  );

endinterface

// File: rtl/halt_drain_ctrl_drain_timer.sv
// Drain watchdog: 16-bit up counter that flags its terminal count at DRAIN_MAX-1.
module drain_timer
  import halt_drain_ctrl_pkg::*;
#(
  parameter int DRAIN_MAX = DEF_DRAIN_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TIMER_W'(DRAIN_MAX - 1));

endmodule

// File: rtl/halt_drain_ctrl.sv
// Halt/drain controller: counts in-flight instructions, drains on halt, then raises isHalt.
// Define HALT_DRAIN_TRACE_EN for simulation-only trace messages on state changes and protocol errors.
module halt_drain_ctrl
  import halt_drain_ctrl_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int DRAIN_MAX = DEF_DRAIN_MAX
) (
  input logic              clk,
  input logic              reset,
  halt_drain_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  halt_state_t      state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             counted_issue, halt_issue, drain_issue;
  logic             retire_ok, under_flow, over_flow, proto_evt, timer_tc;

  drain_timer #(.DRAIN_MAX(DRAIN_MAX)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != ST_DRAIN),
    .enable (state == ST_DRAIN),
    .tc     (timer_tc)
  );

  // A retire is only accepted if something is actually in flight, or arrives this cycle.
  always_comb begin
    counted_issue = (state == ST_RUN) && bus.issue_v && !bus.issue_halt;
    halt_issue    = (state == ST_RUN) && bus.issue_v && bus.issue_halt;
    drain_issue   = (state == ST_DRAIN) && bus.issue_v;
    retire_ok     = bus.wb_v && ((count != '0) || counted_issue);
    under_flow    = bus.wb_v && !retire_ok;
    over_flow     = counted_issue && !bus.wb_v && (count == CNT_MAX);
    proto_evt     = under_flow || over_flow || drain_issue;

    count_next = count;
    if (counted_issue && !retire_ok && !over_flow) begin
      count_next = count + 1'b1;
    end else if (retire_ok && !counted_issue) begin
      count_next = count - 1'b1;
    end

    state_next = state;
    case (state)
      ST_RUN:   if (halt_issue) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (count_next == '0) begin
          state_next = ST_HALTED;
        end else if (timer_tc) begin
          state_next = ST_TIMEOUT;
        end
      end
      default:  state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_RUN;
      count          <= '0;
      bus.W_v        <= 1'b0;
      bus.stop_fetch <= 1'b0;
      bus.isHalt     <= 1'b0;
      bus.proto_err  <= 1'b0;
      bus.drain_err  <= 1'b0;
    end else begin
      state          <= state_next;
      count          <= count_next;
      bus.W_v        <= retire_ok;
      bus.stop_fetch <= (state_next != ST_RUN);
      bus.isHalt     <= (state_next == ST_HALTED) || (state_next == ST_TIMEOUT);
      bus.proto_err  <= bus.proto_err || proto_evt;
      bus.drain_err  <= bus.drain_err || (state_next == ST_TIMEOUT);
    end
  end

  assign bus.inflight = count;

`ifdef HALT_DRAIN_TRACE_EN
  int unsigned trace_cycle;
  int unsigned trace_drain;

  always_ff @(posedge clk) begin
    if (reset) begin
      trace_cycle <= 0;
      trace_drain <= 0;
    end else begin
      trace_cycle <= trace_cycle + 1;
      trace_drain <= (state == ST_DRAIN) ? trace_drain + 1 : 0;
      if (state != ST_DRAIN && state_next == ST_DRAIN)
        $display("[halt_drain_ctrl] cycle %0d: enter DRAIN, inflight=%0d", trace_cycle, count_next);
      if (state != ST_HALTED && state_next == ST_HALTED)
        $display("[halt_drain_ctrl] cycle %0d: enter HALTED after %0d drain cycles", trace_cycle, trace_drain + 1);
      if (state != ST_TIMEOUT && state_next == ST_TIMEOUT)
        $display("[halt_drain_ctrl] cycle %0d: enter TIMEOUT", trace_cycle);
      if (proto_evt)
        $display("[halt_drain_ctrl] cycle %0d: protocol error (under=%0b over=%0b drain_issue=%0b)",
                 trace_cycle, under_flow, over_flow, drain_issue);
    end
  end
`endif

endmodule
